// File: rtl/bet_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bet_pkg
// Brief   : Shared constants, bet field widths and FSM state type for the
//           bet collector and its chip qualifier.
// Revision: 1.0  initial release
// ============================================================================
package bet_pkg;

    localparam int COLOR_W = 2;
    localparam int OPC_W   = 6;
    localparam int BET_W   = COLOR_W + OPC_W;

    localparam logic [OPC_W-1:0] OP_SPIN = 6'b111110;
    localparam logic [OPC_W-1:0] OP_NONE = 6'b111111;

    typedef enum logic {
        COLLECT = 1'b0,
        SPIN    = 1'b1
    } state_e;

    // A stored bet is the chip colour field on top of the key opcode
    function automatic logic [BET_W-1:0] pack_bet(input logic [COLOR_W-1:0] color,
                                                  input logic [OPC_W-1:0]   opcode);
        return {color, opcode};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bet_collector_chip_qualifier.sv
`default_nettype none
// ============================================================================
// Module  : chip_qualifier
// Brief   : Synchronises the raw chip colour, waits for it to hold steady and
//           enforces one physical chip per accepted bet.
// Revision: 1.0  initial release
// ============================================================================
module chip_qualifier
    import bet_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         chip_color_i,
    input  logic               accept_i,
    output logic               chip_stable_o,
    output logic [COLOR_W-1:0] chip_color_sync_o,
    output logic               chip_ready_o
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             w_no_chip;

    assign w_no_chip         = (sync2_q == 3'b000);
    assign chip_stable_o     = (cnt_q == CNT_MAX);
    // Only the low colour bits are stored in a bet
    assign chip_color_sync_o = sync2_q[COLOR_W-1:0];
    assign chip_ready_o      = chip_stable_o & ~w_no_chip & armed_q;

    // Two-flop synchroniser and saturating stability counter; the counter
    // restarts on the edge where the synchronised value is about to change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            cnt_q   <= '0;
        end else begin
            sync1_q <= chip_color_i;
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Arm flag: consumed by an accepted bet, restored once the board is
    // seen empty and steady
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b1;
        end else if (accept_i) begin
            armed_q <= 1'b0;
        end else if (chip_stable_o && w_no_chip) begin
            armed_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bet_collector.sv
`default_nettype none
// ============================================================================
// Module  : bet_collector
// Brief   : Qualifies keypresses against a freshly placed chip, stores up to
//           MAX_BETS packed bets, freezes the table during a spin and clears
//           it on spin completion.
// Revision: 1.0  initial release
// ============================================================================
module bet_collector
    import bet_pkg::*;
#(
    parameter int MAX_BETS      = 12,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [5:0]                bet_opcode,
    input  logic [2:0]                chip_color,
    input  logic                      spin_done,
    output logic [8*MAX_BETS-1:0]     bets_flat,
    output logic [3:0]                bet_count,
    output logic                      spin_active,
    output logic                      bet_accept,
    output logic                      bet_reject,
    output logic                      chip_ready
);

    state_e           state_q;
    logic [BET_W-1:0] slot_q [MAX_BETS];
    logic [3:0]       count_q;
    logic             accept_q;
    logic             reject_q;
    logic             key_valid_q;

    logic               w_chip_stable;
    logic [COLOR_W-1:0] w_color;
    logic               w_key_evt;
    logic               w_collect_evt;
    logic               w_is_none;
    logic               w_is_spin;
    logic               w_full;
    logic               w_empty;
    logic               w_can_store;
    logic               w_accept;
    logic               w_reject;
    logic               w_go_spin;

    chip_qualifier #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chip_qualifier (
        .clock             (clock),
        .reset             (reset),
        .chip_color_i      (chip_color),
        .accept_i          (w_accept),
        .chip_stable_o     (w_chip_stable),
        .chip_color_sync_o (w_color),
        .chip_ready_o      (chip_ready)
    );

    assign w_key_evt     = key_valid & ~key_valid_q;
    assign w_collect_evt = w_key_evt & (state_q == COLLECT);
    assign w_is_none     = (bet_opcode == OP_NONE);
    assign w_is_spin     = (bet_opcode == OP_SPIN);
    assign w_full        = (count_q == 4'(MAX_BETS));
    assign w_empty       = (count_q == 4'd0);
    assign w_can_store   = chip_ready & w_chip_stable & ~w_full;

    assign w_go_spin = w_collect_evt & w_is_spin & ~w_empty;
    assign w_accept  = w_collect_evt & ~w_is_none & ~w_is_spin & w_can_store;
    assign w_reject  = w_collect_evt & ~w_is_none &
                       (w_is_spin ? w_empty : ~w_can_store);

    assign spin_active = (state_q == SPIN);
    assign bet_count   = count_q;
    assign bet_accept  = accept_q;
    assign bet_reject  = reject_q;

    generate
        for (genvar gi = 0; gi < MAX_BETS; gi++) begin : g_flat
            assign bets_flat[8*gi +: 8] = slot_q[gi];
        end
    endgenerate

    // Previous key level for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
        end
    end

    // Collect/spin FSM with the slot table, count and result pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            count_q  <= 4'd0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            for (int i = 0; i < MAX_BETS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            accept_q <= w_accept;
            reject_q <= w_reject;
            case (state_q)
                COLLECT: begin
                    if (w_go_spin) begin
                        state_q <= SPIN;
                    end else if (w_accept) begin
                        for (int i = 0; i < MAX_BETS; i++) begin
                            if (count_q == 4'(i)) begin
                                slot_q[i] <= pack_bet(w_color, bet_opcode);
                            end
                        end
                        count_q <= count_q + 1'b1;
                    end
                end
                SPIN: begin
                    // Keys are dropped here, including one coincident with spin_done
                    if (spin_done) begin
                        state_q <= COLLECT;
                        count_q <= 4'd0;
                        for (int i = 0; i < MAX_BETS; i++) begin
                            slot_q[i] <= '0;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bet_collector.md
Name: bet_collector

Overview:
- Sits between the PS/2 decode path (keyboard-to-bet opcode) plus the Arduino chip-colour inputs and the regfile bet inputs; replaces ad-hoc bet latching in the top level.
- Qualifies each keypress against a stable, freshly placed chip and stores up to MAX_BETS packed bets.
- Recognises the spin command and freezes the bet table while a spin is in progress.
- Clears the table when the processor signals spin completion.

Parameters:
- MAX_BETS, 12, number of bet slots (1..15).
- STABLE_CYCLES, 1000, consecutive cycles the synchronised chip colour must hold before it is trusted.
- OP_SPIN, 6'b111110, opcode that starts a spin.
- OP_NONE, 6'b111111, opcode meaning no valid key; always ignored.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  PS/2 byte-ready; level or pulse, rising edge is the event
- bet_opcode  in  6  decoded opcode, valid while key_valid is high
- chip_color  in  3  raw Arduino colour bits; 000 = no chip
- spin_done  in  1  one-cycle pulse from processor/payout logic
- bets_flat  out  8*MAX_BETS  slot i at [8i+7:8i], packed as {color[1:0], opcode[5:0]}; unused slots read 0
- bet_count  out  4  number of stored bets
- spin_active  out  1  high while in SPIN
- bet_accept  out  1  one-cycle pulse: bet stored
- bet_reject  out  1  one-cycle pulse: key event refused
- chip_ready  out  1  stable chip present and armed

Behaviour:
- Reset (async, active-high): all outputs 0, state COLLECT, table cleared, armed=1, stability counter 0. Reset mid-spin aborts the spin and clears everything.
- chip_color path:
  - 2-flop synchroniser, then stability counter.
  - Counter resets on any change of the synchronised value; saturates at STABLE_CYCLES.
  - chip_stable = counter==STABLE_CYCLES.
- One chip per bet:
  - armed clears on accept.
  - armed sets again only when chip_stable and colour==000.
  - chip_ready = chip_stable & colour!=000 & armed.
- key_valid path: registered; key_evt = key_valid & ~key_valid_q (single cycle per event).
- State COLLECT, on key_evt:
  - opcode==OP_NONE: ignore, no pulse.
  - opcode==OP_SPIN and bet_count>0: go to SPIN. No accept or reject pulse.
  - opcode==OP_SPIN and bet_count==0: bet_reject.
  - any other opcode with chip_ready and bet_count<MAX_BETS: write slot[bet_count], bet_count+1, bet_accept.
  - any other opcode when not chip_ready or table full: bet_reject, table unchanged.
- State SPIN:
  - spin_active=1; table and count frozen.
  - key_evt ignored silently.
  - On spin_done: clear table and count, go to COLLECT. armed is left unchanged.
- spin_done in COLLECT is ignored.
- Simultaneous key_evt and spin_done in SPIN: spin_done wins, the key is dropped.
- Latency:
  - key_valid rise to key_evt: 1 cycle.
  - key_evt to bets_flat/bet_count/bet_accept update: same clock edge, all registered.
  - spin_active rises on the edge that decodes OP_SPIN.
- bet_accept and bet_reject are never high together. Each is a one-cycle registered pulse.
- bet_count never exceeds MAX_BETS and never wraps.

Decomposition:
- Shared package bet_pkg holds:
  - OP_SPIN and OP_NONE constants.
  - Bet field widths (COLOR_W=2, OPC_W=6, BET_W=8).
  - State encoding COLLECT=1'b0, SPIN=1'b1.
- One natural sub-module, chip_qualifier: synchroniser, stability counter and armed flag; outputs chip_stable, chip_color_sync and chip_ready.
- The FSM, edge detect and slot table stay in bet_collector.

Test Plan (bench uses STABLE_CYCLES=4):
- Reset check: assert reset mid-cycle -> all outputs 0 immediately (asynchronous), bets_flat=0.
- Single bet: chip_color=3'b101 held 6 cycles, then key_valid pulse with opcode 6'h05 -> bet_accept 1 cycle, bets_flat[7:0]=8'h45, bet_count=1.
- One-chip rule: without removing the chip, a second key with opcode 6'h07 -> bet_reject, count stays 1. Then drive 000 for 6 cycles and colour 3'b110 for 6 cycles, key 6'h07 -> slot1=8'h87, count=2.
- Spin guard and freeze:
  - OP_SPIN with count 0 -> bet_reject, spin_active stays 0.
  - After 2 bets, OP_SPIN -> spin_active=1.
  - Key 6'h09 with chip ready during SPIN -> no pulses, table unchanged.
- Spin completion: spin_done pulse together with a key_evt in SPIN -> next cycle spin_active=0, bet_count=0, bets_flat=0, no accept.
- Full and glitch cases:
  - Fill 12 bets; 13th key -> bet_reject, count stays 12.
  - Chip colour toggling every 2 cycles -> chip_ready never asserts, every key is rejected.
